mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port program/data RAM between the CPU (MAR/MBR path) and a program loader/debug port.
//  Each requester runs a req/ack handshake. The arbiter owns the RAM pins (ram_rw, address, data_out, data_in).
//  Fixed CPU priority with a starvation limit guarantees loader progress.
//  Sits between the CPU top and the RAM instance; the CPU top stretches its memory cycles while waiting for ack.
// PARAMETERS
//  ADDR_W      8   RAM address width
//  DATA_W      16  RAM data width
//  RD_LAT      1   RAM read latency in cycles (>=1); ram_rdata is valid RD_LAT cycles after address is presented
//  STARVE_LIM  4   consecutive CPU grants allowed while ldr_req is pending (>=1)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  cpu_req    in   1       CPU access request, level; held with cpu_we/addr/wdata stable until cpu_ack
//  cpu_we     in   1       1=write, 0=read
//  cpu_addr   in   ADDR_W  CPU address (MAR)
//  cpu_wdata  in   DATA_W  CPU write data (MBR)
//  cpu_ack    out  1       one-cycle completion pulse
//  cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1
//  ldr_req    in   1       loader request, same rules as cpu_req
//  ldr_we     in   1       loader write enable
//  ldr_addr   in   ADDR_W  loader address
//  ldr_wdata  in   DATA_W  loader write data
//  ldr_ack    out  1       one-cycle completion pulse
//  ldr_rdata  out  DATA_W  read data, valid while ldr_ack=1
//  ram_rw     out  1       1=write RAM, 0=read (same polarity as the CPU RAM interface)
//  ram_addr   out  ADDR_W  registered RAM address
//  ram_wdata  out  DATA_W  registered RAM write data
//  ram_rdata  in   DATA_W  RAM read data
//  owner      out  1       0=CPU, 1=loader; current or last grant
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; starvation count=0; latch registers=0.
//  FSM states:
//  - IDLE: samples req at each edge.
//    - Winner is CPU if cpu_req=1 and (ldr_req=0 or starve_cnt<STARVE_LIM); otherwise loader.
//    - On a grant: latch we/addr/wdata into the ram_* registers and set owner. Next state: ACCESS.
//  - ACCESS:
//    - Write: ram_rw=1 for exactly 1 cycle, then go to ACK.
//    - Read: ram_rw=0; hold RD_LAT cycles (down-counter), capture ram_rdata into the winner's rdata register, then go to ACK.
//  - ACK: winner's ack=1 for 1 cycle; ram_rw=0. Next state: IDLE.
//  Latency from grant edge to ack: write=2 cycles; read=RD_LAT+1 cycles.
//  Requester drops req the cycle after it samples ack=1. The IDLE cycle after ACK therefore sees the new level.
//  A req still high after ack is treated as a new request.
//  starve_cnt:
//  - +1 on each CPU grant while ldr_req=1 (saturates at STARVE_LIM).
//  - Cleared on a loader grant, or in any IDLE cycle with ldr_req=0.
//  Simultaneous requests below the limit: CPU wins.
//  Requests arriving during ACCESS/ACK wait; none are lost or reordered within one requester.
//  ram_addr/ram_wdata hold their value outside ACCESS. ram_rw is never 1 outside ACCESS.
//  The non-winning ack is always 0. The two acks are never high together.
//  Each rdata register holds its last captured value between accesses.
//  Reset mid-operation: the access is aborted immediately; no ack is issued; a partial write cannot be repeated.
//  Req deasserted before ack (protocol violation): the access completes; the ack is still pulsed.
// STRUCTURE
//  Shared header mem_arb_defs.vh holds:
//  - state encodings (ST_IDLE, ST_ACCESS, ST_ACK)
//  - OWNER_CPU=0 and OWNER_LDR=1 constants
//  Sub-module arb_pick (combinational winner and starve_cnt next-value logic) keeps the fairness rule unit-testable.
//  The FSM, latency counter and data registers live in mem_port_arbiter.
// TESTING
//  1. CPU write addr 0x10 data 0xBEEF, then read 0x10 (RD_LAT=1) -> ram_rw=1 for exactly 1 cycle; cpu_ack 2 cycles after grant; then cpu_rdata=0xBEEF with ack 2 cycles after grant.
//  2. cpu_req and ldr_req rise in the same cycle -> CPU granted first (owner=0); loader is acked next; acks never overlap.
//  3. CPU back-to-back reads with ldr_req held high, STARVE_LIM=4 -> exactly 4 CPU grants, then loader granted; counter back to 0.
//  4. Loader writes 0x0000..0x00FF to addresses 0..255 while the CPU idles -> RAM contents match; address 255 is followed by 0 with no glitch on ram_rw.
//  5. rst_n low during a read ACCESS -> outputs 0 next; no ack; after release, the first request is served normally.
//  6. RD_LAT=3 build, loader read -> ldr_ack 4 cycles after grant, with correct data.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the RAM port arbiter: FSM encodings, owner codes and
// the width helper for the starvation counter.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LDR = 1'b1;

  // Bits needed to hold 0..lim inclusive.
  function automatic int cnt_width(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational fairness rule: picks the IDLE-cycle winner and computes the
// next starvation count. CPU has priority until the loader has waited STARVE_LIM grants.
module arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 3
) (
  input  logic             idle,
  input  logic             cpu_req,
  input  logic             ldr_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant,
  output logic             winner,
  output logic [CNT_W-1:0] starve_next
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  always_comb begin
    grant       = 1'b0;
    winner      = OWNER_CPU;
    starve_next = starve_cnt;
    if (idle) begin
      if (cpu_req && (!ldr_req || (starve_cnt < LIM))) begin
        grant  = 1'b1;
        winner = OWNER_CPU;
      end else if (ldr_req) begin
        grant  = 1'b1;
        winner = OWNER_LDR;
      end
      // A loader grant or an idle loader resets the count; CPU wins over a waiting loader add one.
      if (grant && (winner == OWNER_LDR)) begin
        starve_next = '0;
      end else if (!ldr_req) begin
        starve_next = '0;
      end else if (grant && (starve_cnt < LIM)) begin
        starve_next = starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the CPU and the loader/debug port.
// Each request is one IDLE -> ACCESS -> ACK pass; all RAM pins and acks are registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              owner
);

  localparam int CNT_W = cnt_width(STARVE_LIM);
  localparam int LAT_W = $clog2(RD_LAT + 1);

  // Handshake: a requester holds req with we/addr/wdata stable until it sees
  // its ack high for one cycle, then drops req; a req still high is a new request.
  logic [1:0]       state;
  logic [LAT_W-1:0] lat_cnt;
  logic             we_q;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_next;
  logic             grant;
  logic             winner;

  arb_pick #(
    .STARVE_LIM (STARVE_LIM),
    .CNT_W      (CNT_W)
  ) u_pick (
    .idle        (state == ST_IDLE),
    .cpu_req     (cpu_req),
    .ldr_req     (ldr_req),
    .starve_cnt  (starve_cnt),
    .grant       (grant),
    .winner      (winner),
    .starve_next (starve_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      we_q       <= 1'b0;
      starve_cnt <= '0;
      cpu_ack    <= 1'b0;
      ldr_ack    <= 1'b0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
      ram_rw     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      owner      <= OWNER_CPU;
    end else begin
      starve_cnt <= starve_next;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            ram_addr  <= (winner == OWNER_LDR) ? ldr_addr  : cpu_addr;
            ram_wdata <= (winner == OWNER_LDR) ? ldr_wdata : cpu_wdata;
            ram_rw    <= (winner == OWNER_LDR) ? ldr_we    : cpu_we;
            we_q      <= (winner == OWNER_LDR) ? ldr_we    : cpu_we;
            owner     <= winner;
            lat_cnt   <= LAT_W'(RD_LAT - 1);
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (we_q) begin
            ram_rw  <= 1'b0;
            cpu_ack <= (owner == OWNER_CPU);
            ldr_ack <= (owner == OWNER_LDR);
            state   <= ST_ACK;
          end else if (lat_cnt == '0) begin
            if (owner == OWNER_LDR) ldr_rdata <= ram_rdata;
            else                    cpu_rdata <= ram_rdata;
            cpu_ack <= (owner == OWNER_CPU);
            ldr_ack <= (owner == OWNER_LDR);
            state   <= ST_ACK;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        ST_ACK: begin
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
          ram_rw  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RD_LAT=1 instance plus an RD_LAT=3 instance,
// each with a behavioural RAM; acks are scored against expected queues.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;

  logic        cpu_req, cpu_we, cpu_ack;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        ldr_req, ldr_we, ldr_ack;
  logic [7:0]  ldr_addr;
  logic [15:0] ldr_wdata, ldr_rdata;
  logic        ram_rw, owner;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;

  logic        cpu_req_3, cpu_we_3, cpu_ack_3;
  logic [7:0]  cpu_addr_3;
  logic [15:0] cpu_wdata_3, cpu_rdata_3;
  logic        ldr_req_3, ldr_we_3, ldr_ack_3;
  logic [7:0]  ldr_addr_3;
  logic [15:0] ldr_wdata_3, ldr_rdata_3;
  logic        ram_rw_3, owner_3;
  logic [7:0]  ram_addr_3;
  logic [15:0] ram_wdata_3, ram_rdata_3;

  logic [15:0] mem  [256];
  logic [15:0] mem3 [256];
  logic [15:0] rd3_p1, rd3_p2;

  logic [16:0] cpu_exp_q[$];
  logic [16:0] ldr_exp_q[$];
  logic [16:0] cpu3_exp_q[$];
  logic [16:0] ldr3_exp_q[$];
  logic [16:0] e;

  int n_checks = 0;
  int n_errors = 0;
  int rw_run   = 0;
  int rw_run_3 = 0;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .STARVE_LIM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .owner(owner)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3), .STARVE_LIM(4)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req_3), .cpu_we(cpu_we_3), .cpu_addr(cpu_addr_3), .cpu_wdata(cpu_wdata_3),
    .cpu_ack(cpu_ack_3), .cpu_rdata(cpu_rdata_3),
    .ldr_req(ldr_req_3), .ldr_we(ldr_we_3), .ldr_addr(ldr_addr_3), .ldr_wdata(ldr_wdata_3),
    .ldr_ack(ldr_ack_3), .ldr_rdata(ldr_rdata_3),
    .ram_rw(ram_rw_3), .ram_addr(ram_addr_3), .ram_wdata(ram_wdata_3), .ram_rdata(ram_rdata_3),
    .owner(owner_3)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Behavioural RAMs: combinational read for RD_LAT=1, two-stage pipeline for RD_LAT=3.
  always @(posedge clk) begin
    if (ram_rw) mem[ram_addr] <= ram_wdata;
    if (ram_rw_3) mem3[ram_addr_3] <= ram_wdata_3;
    rd3_p1 <= mem3[ram_addr_3];
    rd3_p2 <= rd3_p1;
  end
  assign ram_rdata   = mem[ram_addr];
  assign ram_rdata_3 = rd3_p2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expected entry per ack, mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      rw_run   = 0;
      rw_run_3 = 0;
    end else begin
      if (cpu_ack || ldr_ack) check("ack_overlap", {31'd0, cpu_ack & ldr_ack}, 32'd0);
      if (cpu_ack) begin
        check("cpu_ack_owner", {31'd0, owner}, 32'd0);
        if (cpu_exp_q.size() == 0) check("cpu_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = cpu_exp_q.pop_front();
          if (e[16]) check("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, e[15:0]});
        end
      end
      if (ldr_ack) begin
        check("ldr_ack_owner", {31'd0, owner}, 32'd1);
        if (ldr_exp_q.size() == 0) check("ldr_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = ldr_exp_q.pop_front();
          if (e[16]) check("ldr_rdata", {16'd0, ldr_rdata}, {16'd0, e[15:0]});
        end
      end
      if (cpu_ack_3) begin
        if (cpu3_exp_q.size() == 0) check("cpu3_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = cpu3_exp_q.pop_front();
          if (e[16]) check("cpu3_rdata", {16'd0, cpu_rdata_3}, {16'd0, e[15:0]});
        end
      end
      if (ldr_ack_3) begin
        check("ldr3_ack_owner", {31'd0, owner_3}, 32'd1);
        if (ldr3_exp_q.size() == 0) check("ldr3_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = ldr3_exp_q.pop_front();
          if (e[16]) check("ldr3_rdata", {16'd0, ldr_rdata_3}, {16'd0, e[15:0]});
        end
      end
      if (ram_rw) rw_run++;
      else if (rw_run != 0) begin
        check("ram_rw_pulse_width", rw_run, 32'd1);
        rw_run = 0;
      end
      if (ram_rw_3) rw_run_3++;
      else if (rw_run_3 != 0) begin
        check("ram_rw3_pulse_width", rw_run_3, 32'd1);
        rw_run_3 = 0;
      end
    end
  end

  // Driver tasks. port: 0=cpu, 1=ldr, 2=cpu (RD_LAT=3), 3=ldr (RD_LAT=3)
  task automatic drive(input int port, input logic req, input logic we,
                       input logic [7:0] addr, input logic [15:0] wdata);
    case (port)
      0: begin cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
      1: begin ldr_req = req; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; end
      2: begin cpu_req_3 = req; cpu_we_3 = we; cpu_addr_3 = addr; cpu_wdata_3 = wdata; end
      default: begin ldr_req_3 = req; ldr_we_3 = we; ldr_addr_3 = addr; ldr_wdata_3 = wdata; end
    endcase
  endtask

  function automatic logic ack_of(input int port);
    case (port)
      0: return cpu_ack;
      1: return ldr_ack;
      2: return cpu_ack_3;
      default: return ldr_ack_3;
    endcase
  endfunction

  task automatic push_exp(input int port, input logic [16:0] ent);
    case (port)
      0: cpu_exp_q.push_back(ent);
      1: ldr_exp_q.push_back(ent);
      2: cpu3_exp_q.push_back(ent);
      default: ldr3_exp_q.push_back(ent);
    endcase
  endtask

  // One uncontended access; lat counts clock edges from req rising to ack seen.
  task automatic access(input int port, input logic we, input logic [7:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rd_exp, input int lat);
    int  n;
    logic got;
    push_exp(port, {~we, we ? 16'h0000 : rd_exp});
    @(posedge clk); #1;
    drive(port, 1'b1, we, addr, wdata);
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      got = ack_of(port);
    end
    drive(port, 1'b0, we, addr, wdata);
    check("ack_seen", {31'd0, got}, 32'd1);
    check("ack_latency", n, lat);
  endtask

  // Both requesters hold req; CPU must get exactly STARVE_LIM grants before the loader.
  task automatic starve_run;
    int   n;
    int   cpu_grants;
    logic got;
    for (int k = 0; k < 4; k++) cpu_exp_q.push_back({1'b1, 16'hBEEF});
    ldr_exp_q.push_back({1'b1, 16'hBEEF});
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 8'h10, 16'h0);
    drive(1, 1'b1, 1'b0, 8'h10, 16'h0);
    n = 0;
    cpu_grants = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (cpu_ack) cpu_grants++;
      got = ldr_ack;
    end
    drive(0, 1'b0, 1'b0, 8'h10, 16'h0);
    drive(1, 1'b0, 1'b0, 8'h10, 16'h0);
    check("starve_ldr_served", {31'd0, got}, 32'd1);
    check("starve_cpu_grants", cpu_grants, 32'd4);
  endtask

  initial begin : stim
    int   n;
    int   bad;
    logic got;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(2, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(3, 1'b0, 1'b0, 8'h00, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_ack",   {31'd0, cpu_ack}, 32'd0);
    check("rst_ldr_ack",   {31'd0, ldr_ack}, 32'd0);
    check("rst_ram_rw",    {31'd0, ram_rw}, 32'd0);
    check("rst_ram_addr",  {24'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", {16'd0, ram_wdata}, 32'd0);
    check("rst_owner",     {31'd0, owner}, 32'd0);
    check("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    check("rst_ldr_rdata", {16'd0, ldr_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // CPU write then read back
    access(0, 1'b1, 8'h10, 16'hBEEF, 16'h0000, 2);
    access(0, 1'b0, 8'h10, 16'h0000, 16'hBEEF, 2);

    // Simultaneous requests: CPU first, loader next
    cpu_exp_q.push_back({1'b1, 16'hBEEF});
    ldr_exp_q.push_back({1'b0, 16'h0000});
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 8'h10, 16'h0000);
    drive(1, 1'b1, 1'b1, 8'h20, 16'h2222);
    n = 0;
    while (!(cpu_ack || ldr_ack) && n < 100) begin @(posedge clk); #1; n++; end
    check("tie_first_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    check("tie_first_latency", n, 32'd2);
    drive(0, 1'b0, 1'b0, 8'h10, 16'h0000);
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin @(posedge clk); #1; n++; got = ldr_ack; end
    drive(1, 1'b0, 1'b1, 8'h20, 16'h2222);
    check("tie_ldr_ack_seen", {31'd0, got}, 32'd1);
    check("tie_ldr_latency", n, 32'd3);
    access(0, 1'b0, 8'h20, 16'h0000, 16'h2222, 2);

    // Starvation limit, twice to show the count returns to zero
    for (int r = 0; r < 2; r++) starve_run();

    // Loader fill of the whole address space, wrapping 255 -> 0
    for (int i = 0; i < 256; i++) access(1, 1'b1, 8'(i), 16'(i), 16'h0000, 2);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 16'(i)) bad++;
    check("ldr_fill_bad_words", bad, 32'd0);
    access(1, 1'b0, 8'h00, 16'h0000, 16'h0000, 2);
    access(1, 1'b0, 8'hFF, 16'h0000, 16'h00FF, 2);

    // Reset while a CPU read is in ACCESS
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 8'h20, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    drive(0, 1'b0, 1'b0, 8'h20, 16'h0000);
    check("midrst_ram_addr",  {24'd0, ram_addr}, 32'd0);
    check("midrst_ram_wdata", {16'd0, ram_wdata}, 32'd0);
    check("midrst_ldr_rdata", {16'd0, ldr_rdata}, 32'd0);
    check("midrst_ram_rw",    {31'd0, ram_rw}, 32'd0);
    got = 1'b0;
    repeat (3) begin @(posedge clk); #1; got = got | cpu_ack; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; got = got | cpu_ack | ldr_ack; end
    check("midrst_no_ack", {31'd0, got}, 32'd0);
    access(0, 1'b0, 8'h20, 16'h0000, 16'h0020, 2);

    // RD_LAT=3 instance
    access(2, 1'b1, 8'h22, 16'h1234, 16'h0000, 2);
    access(2, 1'b1, 8'h30, 16'h5555, 16'h0000, 2);
    access(3, 1'b0, 8'h22, 16'h0000, 16'h1234, 4);
    access(2, 1'b0, 8'h30, 16'h0000, 16'h5555, 4);

    repeat (4) @(posedge clk);
    check("cpu_queue_drained",  cpu_exp_q.size(), 32'd0);
    check("ldr_queue_drained",  ldr_exp_q.size(), 32'd0);
    check("cpu3_queue_drained", cpu3_exp_q.size(), 32'd0);
    check("ldr3_queue_drained", ldr3_exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
